fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequencing controller for the fetch stage. It drives pc_write, pc_write_back_value and clear_instruction.
- It arbitrates between the reset vector load, taken-branch redirects, load-use stalls and external interrupts.
- Sits between the hazard/branch logic in decode/execute and the fetch stage. It is the only source of PC redirects and fetch bubbles.

Parameters:
- RESET_VECTOR, 32, first instruction-memory address loaded after reset (2^5).
- INT_BUBBLES, 2, number of NOP cycles injected before jumping to the interrupt handler (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- current_pc  input  32  PC of the instruction currently being fetched.
- branch_taken  input  1  resolved taken branch/jump this cycle.
- branch_target  input  32  target address for branch_taken.
- load_use_stall  input  1  hazard unit requests a fetch freeze this cycle.
- interrupt  input  1  external interrupt request; level, sampled every cycle.
- int_vector  input  32  interrupt handler address.
- pc_write  output  1  fetch loads pc_write_back_value instead of PC+1.
- pc_write_back_value  output  32  next PC when pc_write=1.
- clear_instruction  output  1  fetch substitutes NOP for the fetched word.
- int_save_pc  output  32  return address to push for the interrupt.
- int_save_valid  output  1  one-cycle strobe; int_save_pc is valid.
- int_ack  output  1  one-cycle strobe when the interrupt is accepted.

Behaviour:
- State and output timing
  - States: VEC, RUN, INT_FLUSH, INT_JUMP. State register and bubble counter (3 bit) reset asynchronously when reset=0.
  - All outputs are combinational from state plus inputs; no added latency. A decision made in cycle N redirects the PC fetched in cycle N+1.
- Reset values (while reset=0): state=VEC, counter=0, int_pending=0, int_save_pc=0, int_save_valid=0, int_ack=0.
  - In VEC: pc_write=1, pc_write_back_value=RESET_VECTOR, clear_instruction=1.
- VEC: held for exactly one cycle after reset deasserts, with the outputs above. All other inputs are ignored. Next state is RUN.
- int_pending
  - Set on any clk edge where interrupt=1 and state is not INT_FLUSH or INT_JUMP.
  - Cleared on entry to INT_FLUSH.
  - Requests arriving while an interrupt is in progress are dropped.
- RUN, priority order (highest first):
  1. branch_taken=1: pc_write=1, value=branch_target, clear_instruction=1. Stays in RUN. A pending interrupt waits.
  2. int_pending=1 (or interrupt=1 this cycle):
     - Outputs: int_ack=1, clear_instruction=1, pc_write=1, value=current_pc (refetch point is frozen).
     - Latch int_save_pc=current_pc; counter=1.
     - Go to INT_FLUSH, or to INT_JUMP if INT_BUBBLES=1.
  3. load_use_stall=1: pc_write=1, value=current_pc, clear_instruction=0 (same word refetched).
  4. Otherwise: pc_write=0, clear_instruction=0.
- INT_FLUSH
  - Each cycle: pc_write=1, value=current_pc, clear_instruction=1; counter increments.
  - load_use_stall is ignored.
  - branch_taken=1 here overwrites int_save_pc with branch_target, so the branch still resolves on return.
  - Leave for INT_JUMP when counter==INT_BUBBLES.
- INT_JUMP, one cycle:
  - pc_write=1, value=int_vector, clear_instruction=1, int_save_valid=1, int_save_pc held.
  - branch_taken in this cycle overwrites int_save_pc with branch_target and is otherwise ignored.
  - Next state is RUN.
- int_save_pc holds its value until the next interrupt acceptance.
- reset asserted in any state aborts immediately: pending interrupt lost, outputs revert to their reset values.
- No arithmetic other than the 3-bit counter, which never wraps because the counter is bounded by INT_BUBBLES ≤ 7.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: one cycle with pc_write=1, value=32, clear_instruction=1; next cycle pc_write=0.
- Branch: in RUN, branch_taken=1, branch_target=0x0000_0100 for one cycle. Required: same cycle pc_write=1, value=0x100, clear_instruction=1; next cycle pc_write=0.
- Stall: load_use_stall=1 for 2 cycles, current_pc=0x40. Required: pc_write=1, value=0x40, clear_instruction=0 both cycles; no NOP injected.
- Interrupt (INT_BUBBLES=2): interrupt pulse at current_pc=0x50, int_vector=0x200. Required:
  - int_ack at acceptance.
  - clear_instruction=1 for 2 cycles, value=0x50.
  - Then pc_write=1, value=0x200, int_save_valid=1, int_save_pc=0x50.
- Simultaneous events: branch_taken(0x80) and interrupt in the same RUN cycle. Required: branch redirect first; interrupt accepted the following cycle with int_save_pc=current_pc of that cycle. Second case: branch_taken(0x90) during INT_FLUSH gives int_save_pc=0x90 at INT_JUMP.
- Reset mid-interrupt: assert reset during INT_FLUSH. Required: outputs go to reset values asynchronously; after release, VEC sequence runs and int_ack is not re-issued.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Fetch-stage control bundle between the hazard/branch logic and the fetch PC mux.
// master = fetch_controller side; slave = fetch/hazard side.
interface fetch_controller_if;
    logic [31:0] current_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        load_use_stall;
    logic        interrupt;
    logic [31:0] int_vector;
    logic        pc_write;
    logic [31:0] pc_write_back_value;
    logic        clear_instruction;
    logic [31:0] int_save_pc;
    logic        int_save_valid;
    logic        int_ack;

    modport master (
        input  current_pc, branch_taken, branch_target, load_use_stall, interrupt, int_vector,
        output pc_write, pc_write_back_value, clear_instruction, int_save_pc, int_save_valid,
               int_ack
    );

    modport slave (
        output current_pc, branch_taken, branch_target, load_use_stall, interrupt, int_vector,
        input  pc_write, pc_write_back_value, clear_instruction, int_save_pc, int_save_valid,
               int_ack
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencing: reset-vector load, branch redirects, load-use freezes and interrupt entry.
// Outputs are combinational from state and inputs so a decision redirects the very next fetch.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'd32,
    parameter int unsigned INT_BUBBLES  = 2
) (
    input logic              clk,
    input logic              reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {StVec, StRun, StIntFlush, StIntJump} state_e;

    localparam logic [2:0] BubblesLast = 3'(INT_BUBBLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [31:0] save_pc_q, save_pc_d;
    logic        int_req;

    assign int_req = pending_q | bus.interrupt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        save_pc_d = save_pc_q;

        bus.pc_write            = 1'b0;
        bus.pc_write_back_value = bus.current_pc;
        bus.clear_instruction   = 1'b0;
        bus.int_save_valid      = 1'b0;
        bus.int_ack             = 1'b0;

        // Requests seen while an interrupt is already in flight are dropped.
        if (bus.interrupt && state_q != StIntFlush && state_q != StIntJump) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StVec: begin
                bus.pc_write            = 1'b1;
                bus.pc_write_back_value = RESET_VECTOR;
                bus.clear_instruction   = 1'b1;
                state_d                 = StRun;
            end
            StRun: begin
                if (bus.branch_taken) begin
                    bus.pc_write            = 1'b1;
                    bus.pc_write_back_value = bus.branch_target;
                    bus.clear_instruction   = 1'b1;
                end else if (int_req) begin
                    bus.int_ack           = 1'b1;
                    bus.pc_write          = 1'b1;
                    bus.clear_instruction = 1'b1;
                    save_pc_d             = bus.current_pc;
                    cnt_d                 = 3'd1;
                    // Acceptance consumes the request even when flush is skipped.
                    pending_d             = 1'b0;
                    state_d               = (INT_BUBBLES == 1) ? StIntJump : StIntFlush;
                end else if (bus.load_use_stall) begin
                    bus.pc_write = 1'b1;
                end
            end
            StIntFlush: begin
                bus.pc_write          = 1'b1;
                bus.clear_instruction = 1'b1;
                cnt_d                 = cnt_q + 3'd1;
                if (bus.branch_taken) begin
                    save_pc_d = bus.branch_target;
                end
                // The acceptance cycle is bubble 1, so leave once this bubble is the last.
                if (cnt_d == BubblesLast) begin
                    state_d = StIntJump;
                end
            end
            StIntJump: begin
                bus.pc_write            = 1'b1;
                bus.pc_write_back_value = bus.int_vector;
                bus.clear_instruction   = 1'b1;
                bus.int_save_valid      = 1'b1;
                if (bus.branch_taken) begin
                    save_pc_d = bus.branch_target;
                end
                cnt_d   = 3'd0;
                state_d = StRun;
            end
            default: state_d = StVec;
        endcase
    end

    assign bus.int_save_pc = save_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StVec;
            cnt_q     <= 3'd0;
            pending_q <= 1'b0;
            save_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            save_pc_q <= save_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed checks of fetch_controller: reset vector, branch, stall, interrupt entry, overlaps.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_VECTOR(32'd32),
        .INT_BUBBLES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value is only meaningful while pc_write is expected high.
    task automatic chk_out(input string tag, input logic pcw, input logic [31:0] val,
                           input logic clr, input logic ack, input logic sv,
                           input logic [31:0] spc);
        chk($sformatf("%s.pc_write", tag), 32'(bus.pc_write), 32'(pcw));
        if (pcw) chk($sformatf("%s.value", tag), bus.pc_write_back_value, val);
        chk($sformatf("%s.clear", tag), 32'(bus.clear_instruction), 32'(clr));
        chk($sformatf("%s.int_ack", tag), 32'(bus.int_ack), 32'(ack));
        chk($sformatf("%s.save_valid", tag), 32'(bus.int_save_valid), 32'(sv));
        chk($sformatf("%s.save_pc", tag), bus.int_save_pc, spc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b0;
        bus.current_pc     = 32'h0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = 32'h0;
        bus.load_use_stall = 1'b0;
        bus.interrupt      = 1'b0;
        bus.int_vector     = 32'h200;
        #2;
        chk_out("reset", 1'b1, 32'd32, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step();

        // VEC cycle ignores a branch request.
        reset             = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h44;
        #1 chk_out("vec", 1'b1, 32'd32, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        bus.branch_taken = 1'b0;
        #1 chk_out("run_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        #1 chk_out("branch", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        bus.branch_taken = 1'b0;
        #1 chk_out("branch_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        step();
        bus.current_pc     = 32'h40;
        bus.load_use_stall = 1'b1;
        #1 chk_out("stall1", 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        #1 chk_out("stall2", 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        bus.load_use_stall = 1'b0;
        #1 chk_out("stall_end", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Interrupt pulse; stall during flush must not change the bubble.
        step();
        bus.current_pc = 32'h50;
        bus.interrupt  = 1'b1;
        #1 chk_out("int_accept", 1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        bus.interrupt      = 1'b0;
        bus.load_use_stall = 1'b1;
        #1 chk_out("int_flush", 1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'h50);
        step();
        bus.load_use_stall = 1'b0;
        #1 chk_out("int_jump", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h50);
        step();
        #1 chk_out("int_return", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h50);

        // Branch and interrupt together: branch first, interrupt next cycle.
        step();
        bus.current_pc    = 32'h60;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h80;
        bus.interrupt     = 1'b1;
        #1 chk_out("sim_branch", 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h50);
        step();
        bus.branch_taken = 1'b0;
        bus.interrupt    = 1'b0;
        bus.current_pc   = 32'h80;
        #1 chk_out("sim_accept", 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h50);
        // Branch during flush rewrites the return address; new request is dropped.
        step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h90;
        bus.interrupt     = 1'b1;
        #1 chk_out("sim_flush", 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h80);
        step();
        bus.branch_taken = 1'b0;
        #1 chk_out("sim_jump", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h90);
        step();
        bus.interrupt = 1'b0;
        #1 chk_out("sim_dropped", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h90);

        // Reset in the middle of an interrupt flush.
        step();
        bus.current_pc = 32'hA0;
        bus.interrupt  = 1'b1;
        #1 chk_out("mid_accept", 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h90);
        step();
        bus.interrupt = 1'b0;
        #1 chk_out("mid_flush", 1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 32'hA0);
        #1 reset = 1'b0;
        #1 chk_out("mid_async_rst", 1'b1, 32'd32, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step();
        reset = 1'b1;
        #1 chk_out("mid_vec", 1'b1, 32'd32, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        #1 chk_out("mid_run", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        #1 chk_out("mid_run2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
